// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Staged reset sequencer. Holds all reset channels asserted until the debounced
// push-button and the PLL lock are both good. It then waits HOLD_CNT cycles and
// releases the channels one at a time, GAP_CNT cycles apart, starting with
// channel 0. Losing either start condition at any point after ASSERT reasserts
// every channel on the next edge and discards any partial progress.
//
// Optional feature (compile-time macro RST_SEQ_SWRST_EN):
//   Adds sw_rst_req_i. A one-cycle pulse in HOLD, RELEASE or RUN forces ASSERT.
//   The sequencer then stays in ASSERT for HOLD_CNT cycles, whatever go says.
//   Without the macro the port does not exist.
//
// Parameters
//   N_CH      number of staged reset channels (1..8)
//   HOLD_CNT  cycles in HOLD before the first release (>=1)
//   GAP_CNT   cycles between successive channel releases (>=1)
//   DEB_CNT   button debounce stability window in cycles (>=1)
//
// Ports
//   clk_i         in   1     block clock
//   rst_i         in   1     asynchronous active-high reset
//   btn_rst_n_i   in   1     asynchronous push-button, low = pressed
//   pll_locked_i  in   1     asynchronous PLL lock, high = locked
//   sw_rst_req_i  in   1     software reset pulse (RST_SEQ_SWRST_EN only)
//   rst_o         out  N_CH  per-channel reset, active-high, registered
//   ready_o       out  1     high in RUN, when all channels are released
//   state_o       out  2     0 ASSERT, 1 HOLD, 2 RELEASE, 3 RUN
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned HOLD_CNT = 50,
   parameter int unsigned GAP_CNT  = 16,
   parameter int unsigned DEB_CNT  = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            btn_rst_n_i,
   input  logic            pll_locked_i,
`ifdef RST_SEQ_SWRST_EN
   input  logic            sw_rst_req_i,
`endif
   output logic [N_CH-1:0] rst_o,
   output logic            ready_o,
   output logic [1:0]      state_o
);

   // One counter width for every counter: wide enough for the largest
   // parameter, plus one bit of headroom so compares never see a wrap.
   localparam int unsigned MAX_HG = (HOLD_CNT > GAP_CNT) ? HOLD_CNT : GAP_CNT;
   localparam int unsigned MAX_HD = (MAX_HG > DEB_CNT) ? MAX_HG : DEB_CNT;
   localparam int unsigned MAX_P  = (MAX_HD > N_CH) ? MAX_HD : N_CH;
   localparam int unsigned CW     = $clog2(MAX_P) + 1;

   typedef enum logic [1:0] {
      StAssert  = 2'd0,
      StHold    = 2'd1,
      StRelease = 2'd2,
      StRun     = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizers. They reset to 0, so both start conditions read as
   // "not good" straight out of reset.
   // ---------------------------------------------------------------------------
   logic btn_s1, btn_s2;
   logic lock_s1, lock_s2;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
         lock_s1 <= 1'b0;
         lock_s2 <= 1'b0;
      end else begin
         btn_s1  <= btn_rst_n_i;
         btn_s2  <= btn_s1;
         lock_s1 <= pll_locked_i;
         lock_s2 <= lock_s1;
      end
   end

   // ---------------------------------------------------------------------------
   // Button debounce. btn_f follows btn_s2 only once btn_s2 has disagreed with
   // it for DEB_CNT consecutive cycles. Any agreeing cycle restarts the window.
   // ---------------------------------------------------------------------------
   logic          btn_f_q, btn_f_d;
   logic [CW-1:0] deb_q, deb_d;

   always_comb begin
      btn_f_d = btn_f_q;
      deb_d   = '0;
      if (btn_s2 != btn_f_q) begin
         if (deb_q >= CW'(DEB_CNT - 1)) begin
            btn_f_d = btn_s2;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         btn_f_q <= 1'b0;
         deb_q   <= '0;
      end else begin
         btn_f_q <= btn_f_d;
         deb_q   <= deb_d;
      end
   end

   logic go;
   assign go = btn_f_q & lock_s2;

   // ---------------------------------------------------------------------------
   // Software reset. sw_hit forces ASSERT. sw_block keeps the sequencer in
   // ASSERT for HOLD_CNT cycles afterwards.
   // ---------------------------------------------------------------------------
   state_t state_q, state_d;
   logic   sw_hit;
   logic   sw_block;

`ifdef RST_SEQ_SWRST_EN
   logic [CW-1:0] swc_q;

   assign sw_hit   = sw_rst_req_i && (state_q != StAssert);
   assign sw_block = (swc_q != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         swc_q <= '0;
      end else if (sw_hit) begin
         swc_q <= CW'(HOLD_CNT);
      end else if (swc_q != '0) begin
         swc_q <= swc_q - 1'b1;
      end
   end
`else
   assign sw_hit   = 1'b0;
   assign sw_block = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------------
   logic [CW-1:0]   cnt_q, cnt_d;    // HOLD / gap cycle counter
   logic [CW-1:0]   k_q, k_d;        // index of the most recently released channel
   logic [N_CH-1:0] rst_q, rst_d;
   logic            ready_q, ready_d;
   logic            abort;

   assign abort = !go || sw_hit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;

      unique case (state_q)
         StAssert: begin
            cnt_d = '0;
            k_d   = '0;
            if (go && !sw_block) begin
               state_d = StHold;
            end
         end

         StHold: begin
            if (abort) begin
               state_d = StAssert;
               cnt_d   = '0;
               k_d     = '0;
            end else if (cnt_q >= CW'(HOLD_CNT - 1)) begin
               state_d = StRelease;
               cnt_d   = '0;
               k_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StRelease: begin
            if (abort) begin
               state_d = StAssert;
               cnt_d   = '0;
               k_d     = '0;
            end else if (k_q >= CW'(N_CH - 1)) begin
               // Last channel released on the previous edge; no gap wait.
               state_d = StRun;
               cnt_d   = '0;
            end else if (cnt_q >= CW'(GAP_CNT - 1)) begin
               k_d   = k_q + 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StRun: begin
            cnt_d = '0;
            if (abort) begin
               state_d = StAssert;
               k_d     = '0;
            end
         end

         default: begin
            state_d = StAssert;
            cnt_d   = '0;
            k_d     = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state. Each registered output then
   // changes on the same edge as the state it belongs to.
   always_comb begin
      rst_d   = '1;
      ready_d = 1'b0;
      unique case (state_d)
         StAssert, StHold: begin
            rst_d = '1;
         end
         StRelease: begin
            for (int i = 0; i < int'(N_CH); i++) begin
               rst_d[i] = (CW'(i) > k_d);
            end
         end
         StRun: begin
            rst_d   = '0;
            ready_d = 1'b1;
         end
         default: begin
            rst_d = '1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StAssert;
         cnt_q   <= '0;
         k_q     <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
      end
   end

   assign rst_o   = rst_q;
   assign ready_o = ready_q;
   assign state_o = state_q;

endmodule
